// File: rtl/moosic_tone_gen_if.sv
// Note handshake between the moosic note counter (master) and the tone generator (slave).
interface moosic_tone_gen_if;
  logic [7:0] note_in;
  logic       note_valid;
  logic       note_ready;

  modport master (output note_in, output note_valid, input  note_ready);
  modport slave  (input  note_in, input  note_valid, output note_ready);
endinterface

// File: rtl/moosic_tone_gen.sv
// Descrambles accepted note codes with the locking key and plays each one as a
// square wave for DUR_CYCLES clocks, followed by GAP_CYCLES clocks of silence.
module moosic_tone_gen #(
  parameter int unsigned KEY_SIZE   = 4,
  parameter int unsigned DUR_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  moosic_tone_gen_if.slave    note_if,
  input  logic [KEY_SIZE-1:0] key,
  output logic                audio_out,
  output logic                busy,
  output logic                note_done
);

  localparam int unsigned DW = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [7:0]    eff_q;
  logic [DW-1:0] dur_cnt;
  logic [GW-1:0] gap_cnt;
  logic [9:0]    div_cnt;
  logic [7:0]    eff;
  logic [9:0]    half_m1;

  assign eff     = note_if.note_in ^ {(8 / KEY_SIZE){key}};
  // half - 1 = 1023 - 4*eff always fits in 10 bits for any non-rest code
  assign half_m1 = 10'd1023 - {eff_q, 2'b00};

  assign note_if.note_ready = (state == IDLE);
  assign busy               = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      eff_q     <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      div_cnt   <= '0;
      audio_out <= 1'b0;
      note_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          note_done <= 1'b0;
          if (note_if.note_valid) begin
            eff_q     <= eff;
            dur_cnt   <= '0;
            div_cnt   <= '0;
            audio_out <= 1'b0;
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (eff_q != 8'd0) begin
            if (div_cnt == half_m1) begin
              div_cnt   <= '0;
              audio_out <= ~audio_out;
            end else begin
              div_cnt <= div_cnt + 10'd1;
            end
          end
          // expiry overrides the divider so the gap always starts silent
          if (dur_cnt == DW'(DUR_CYCLES - 1)) begin
            dur_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            audio_out <= 1'b0;
            state     <= GAP;
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
          end
        end
        GAP: begin
          audio_out <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt   <= '0;
            note_done <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          audio_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moosic_tone_gen.sv
// Scoreboard bench for moosic_tone_gen: expected per-note waveform statistics are
// queued at accept and compared against a negedge monitor's measurements at note_done.
module tb_moosic_tone_gen;

  localparam int unsigned KS  = 4;
  localparam int unsigned DUR = 64;
  localparam int unsigned GAP = 8;

  logic          clk;
  logic          rst;
  logic [KS-1:0] key;
  logic          audio_out;
  logic          busy;
  logic          note_done;

  moosic_tone_gen_if nif ();

  moosic_tone_gen #(
    .KEY_SIZE   (KS),
    .DUR_CYCLES (DUR),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note_if   (nif),
    .key       (key),
    .audio_out (audio_out),
    .busy      (busy),
    .note_done (note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int busy_cycles;
    int rises;
    int first_rise;
    int period;
    int gap_high;
  } rec_t;

  rec_t exp_q[$];
  rec_t meas_q[$];
  int   total = 0;
  int   bad   = 0;

  // monitor state
  int   m_busy, m_rises, m_first, m_period, m_last, m_gap_high;
  logic m_prev_audio;

  task automatic mon_clear();
    m_busy = 0; m_rises = 0; m_first = -1; m_period = -1; m_last = -1;
    m_gap_high = 0; m_prev_audio = 1'b0;
  endtask

  initial mon_clear();

  always @(negedge clk) begin
    if (rst) begin
      mon_clear();
    end else begin
      if (busy) begin
        if (m_busy >= int'(DUR) && audio_out) m_gap_high++;
        if (audio_out && !m_prev_audio) begin
          m_rises++;
          if (m_first < 0) m_first = m_busy;
          else if (m_period < 0) m_period = m_busy - m_last;
          m_last = m_busy;
        end
        m_busy++;
      end
      m_prev_audio = audio_out;
      if (note_done) begin
        meas_q.push_back('{m_busy, m_rises, m_first, m_period, m_gap_high});
        mon_clear();
      end
    end
  end

  function automatic rec_t model(input logic [7:0] code, input logic [KS-1:0] k);
    rec_t r;
    logic [7:0] e;
    int h;
    e = code ^ {k, k};
    h = 1024 - 4 * int'(e);
    r.busy_cycles = DUR + GAP;
    r.gap_high    = 0;
    r.rises       = 0;
    r.first_rise  = -1;
    r.period      = -1;
    if (e != 8'd0) begin
      for (int m = 1; m * h < int'(DUR); m += 2) r.rises++;
      if (r.rises >= 1) r.first_rise = h;
      if (r.rises >= 2) r.period = 2 * h;
    end
    return r;
  endfunction

  task automatic play_note(input logic [7:0] code, input logic [KS-1:0] k, input bit track);
    int t = 0;
    @(negedge clk);
    nif.note_in = code; key = k; nif.note_valid = 1'b1;
    while (!nif.note_ready && t < 200) begin @(negedge clk); t++; end
    if (!nif.note_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=ready_low exp=ready_high");
    end else if (track) begin
      exp_q.push_back(model(code, k));
    end
    @(negedge clk);
    nif.note_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    rec_t e, m;
    int t = 0;
    while (meas_q.size() == 0 && t < 300) begin @(negedge clk); t++; end
    if (meas_q.size() == 0 || exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_done_timeout got=no_note_done exp=note_done", name);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    m = meas_q.pop_front();
    total++; if (m.busy_cycles !== e.busy_cycles) begin bad++;
      $display("FAIL %s_busy got=%0d exp=%0d", name, m.busy_cycles, e.busy_cycles); end
    total++; if (m.rises !== e.rises) begin bad++;
      $display("FAIL %s_rises got=%0d exp=%0d", name, m.rises, e.rises); end
    total++; if (m.first_rise !== e.first_rise) begin bad++;
      $display("FAIL %s_first_rise got=%0d exp=%0d", name, m.first_rise, e.first_rise); end
    total++; if (m.period !== e.period) begin bad++;
      $display("FAIL %s_period got=%0d exp=%0d", name, m.period, e.period); end
    total++; if (m.gap_high !== e.gap_high) begin bad++;
      $display("FAIL %s_gap_audio got=%0d exp=%0d", name, m.gap_high, e.gap_high); end
    @(negedge clk);
    total++; if (note_done !== 1'b0) begin bad++;
      $display("FAIL %s_done_width got=%0b exp=0", name, note_done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; key = '0; nif.note_in = '0; nif.note_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL reset_audio got=%0b exp=0", audio_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (note_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", note_done); end
    total++; if (nif.note_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", nif.note_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    play_note(8'hFF, 4'h0, 1'b1);
    wait_result("basic_ff");
  endtask

  task automatic test_key_inverted();
    play_note(8'h00, 4'hF, 1'b1);
    wait_result("key_f_00");
  endtask

  task automatic test_rest();
    play_note(8'h00, 4'h0, 1'b1);
    wait_result("rest");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    nif.note_in = 8'hFF; key = 4'h0; nif.note_valid = 1'b1;
    exp_q.push_back(model(8'hFF, 4'h0));
    @(negedge clk);
    nif.note_in = 8'hFE;
    n = 1;
    while (!nif.note_ready && n < 200) begin
      if (n == 20) key = 4'hA;
      if (n == 66) key = 4'h0;
      @(negedge clk); n++;
    end
    total++; if (n !== 73) begin bad++; $display("FAIL b2b_spacing got=%0d exp=73", n); end
    exp_q.push_back(model(8'hFE, 4'h0));
    @(negedge clk);
    nif.note_valid = 1'b0;
    wait_result("b2b_first");
    wait_result("b2b_second");
  endtask

  task automatic test_reset_mid_play();
    int t = 0;
    play_note(8'hFF, 4'h0, 1'b0);
    while (audio_out !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    total++; if (audio_out !== 1'b1) begin bad++; $display("FAIL midrst_setup got=%0b exp=1", audio_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL midrst_audio got=%0b exp=0", audio_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    total++; if (note_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b exp=0", note_done); end
    total++; if (nif.note_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", nif.note_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    play_note(8'hFF, 4'h0, 1'b1);
    wait_result("after_rst");
  endtask

  task automatic test_key_variants();
    play_note(8'hEE, 4'h1, 1'b1);
    wait_result("key1_ee");
    play_note(8'hEE, 4'h0, 1'b1);
    wait_result("key0_ee");
    play_note(8'hFC, 4'h0, 1'b1);
    wait_result("key0_fc");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key_inverted();
    test_rest();
    test_back_to_back();
    test_reset_mid_play();
    test_key_variants();
    total++; if (exp_q.size() !== 0 || meas_q.size() !== 0) begin bad++;
      $display("FAIL leftover got=%0d/%0d exp=0/0", exp_q.size(), meas_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
